// File: rtl/crt_lift_sequencer_pkg.sv
// Shared state encoding, phase type and defaults for the CRT lift/reduction sequencer.
package crt_lift_sequencer_pkg;

    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StRdRst    = 4'd1;
    localparam logic [3:0] StRdWait   = 4'd2;
    localparam logic [3:0] StLift     = 4'd3;
    localparam logic [3:0] StLiftWait = 4'd4;
    localparam logic [3:0] StWrRst    = 4'd5;
    localparam logic [3:0] StWrWait   = 4'd6;
    localparam logic [3:0] StNext     = 4'd7;
    localparam logic [3:0] StFinish   = 4'd8;
    localparam logic [3:0] StErr      = 4'd9;

    typedef enum logic {PhRd = 1'b0, PhWr = 1'b1} phase_e;

    localparam int unsigned N_COEFF_DEF   = 512;
    localparam int unsigned TIMEOUT_W_DEF = 16;
    localparam int unsigned MAX_RETRY_DEF = 3;

    function automatic logic is_busy_state(input logic [3:0] st);
        return !(st == StIdle || st == StFinish || st == StErr);
    endfunction

endpackage

// File: rtl/crt_phase_watchdog.sv
// Per-phase stall watchdog: free-running counter cleared outside wait states, plus the
// re-issue counter shared by the read and write phases.
module crt_phase_watchdog #(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic       i_retry_clr,
    input  logic       i_retry_inc,
    output logic       o_expired,
    output logic [1:0] o_retry
);

    logic [TIMEOUT_W-1:0] r_cnt;
    logic [1:0]           r_retry;

    // Counter saturates at all-ones so the expiry stays visible until the FSM reacts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_retry <= '0;
        end else begin
            if (!i_run) begin
                r_cnt <= '0;
            end else if (!o_expired) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (i_retry_clr) begin
                r_retry <= '0;
            end else if (i_retry_inc) begin
                r_retry <= r_retry + 2'd1;
            end
        end
    end

    assign o_expired = &r_cnt;
    assign o_retry   = r_retry;

endmodule

// File: rtl/crt_lift_sequencer.sv
// Schedules one CRT lift pass: per coefficient offset a DDR read phase, a lift compute and a
// DDR write phase, with watchdog-driven phase re-issue and a sticky error stop.
module crt_lift_sequencer
    import crt_lift_sequencer_pkg::*;
#(
    parameter int unsigned N_COEFF   = N_COEFF_DEF,
    parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF,
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic       i_clk_100,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_lift_type_in,
    input  logic       i_reduction_type_in,
    input  logic [7:0] i_base_in,
    input  logic [7:0] i_base_out,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [9:0] o_coeff_idx,
    output logic       o_iface_rst,
    output logic       o_iface_read_write,
    output logic       o_iface_lift_type,
    output logic       o_iface_red_type,
    output logic [7:0] o_iface_base_in,
    output logic [7:0] o_iface_base_out,
    output logic       o_rst_ddr_offset,
    output logic       o_inc_ddr_offset,
    input  logic       i_iface_done,
    output logic       o_lift_start,
    input  logic       i_lift_done
);

    localparam logic [9:0] LastIdx  = 10'(N_COEFF - 1);
    localparam logic [1:0] RetryMax = 2'(MAX_RETRY);

    logic [3:0] r_state;
    logic [3:0] w_state_d;
    phase_e     w_phase;
    logic       w_wait;
    logic       w_accept;
    logic       w_advance;
    logic       w_expired;
    logic       w_retry_clr;
    logic       w_retry_inc;
    logic [1:0] w_retry;

    logic       r_busy, r_done, r_error, r_read_write, r_lift_start;
    logic       r_rst_ddr_offset, r_inc_ddr_offset;
    logic       r_lift_type, r_red_type;
    logic [7:0] r_base_in, r_base_out;
    logic [9:0] r_coeff_idx;

    crt_phase_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wdog (
        .i_clk       (i_clk_100),
        .i_rst       (i_rst),
        .i_run       (w_wait),
        .i_retry_clr (w_retry_clr),
        .i_retry_inc (w_retry_inc),
        .o_expired   (w_expired),
        .o_retry     (w_retry)
    );

    always_ff @(posedge i_clk_100) begin
        if (i_rst) begin
            r_state          <= StIdle;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
            r_read_write     <= 1'b0;
            r_lift_start     <= 1'b0;
            r_rst_ddr_offset <= 1'b0;
            r_inc_ddr_offset <= 1'b0;
            r_lift_type      <= 1'b0;
            r_red_type       <= 1'b0;
            r_base_in        <= '0;
            r_base_out       <= '0;
            r_coeff_idx      <= '0;
        end else begin
            r_state          <= w_state_d;
            r_busy           <= is_busy_state(w_state_d);
            r_done           <= (w_state_d == StFinish);
            r_error          <= (w_state_d == StErr);
            r_read_write     <= (w_state_d == StWrRst) || (w_state_d == StWrWait);
            r_lift_start     <= (w_state_d == StLift);
            r_rst_ddr_offset <= w_accept;
            r_inc_ddr_offset <= w_advance;
            if (w_accept) begin
                r_lift_type <= i_lift_type_in;
                r_red_type  <= i_reduction_type_in;
                r_base_in   <= i_base_in;
                r_base_out  <= i_base_out;
                r_coeff_idx <= '0;
            end else if (w_advance) begin
                r_coeff_idx <= r_coeff_idx + 10'd1;
            end
        end
    end

    // Read and write waits share the timeout path; the phase picks the re-issue target.
    always_comb begin
        w_state_d   = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_retry_clr = 1'b0;
        w_retry_inc = 1'b0;
        case (r_state)
            StIdle, StErr: begin
                if (i_start) begin
                    w_state_d   = StRdRst;
                    w_accept    = 1'b1;
                    w_retry_clr = 1'b1;
                end
            end
            StRdRst: w_state_d = StRdWait;
            StRdWait, StWrWait: begin
                if (i_iface_done) begin
                    w_state_d = (w_phase == PhRd) ? StLift : StNext;
                end else if (w_expired) begin
                    if (w_retry == RetryMax) begin
                        w_state_d = StErr;
                    end else begin
                        w_state_d   = (w_phase == PhRd) ? StRdRst : StWrRst;
                        w_retry_inc = 1'b1;
                    end
                end
            end
            StLift: w_state_d = StLiftWait;
            StLiftWait: begin
                if (i_lift_done) begin
                    w_state_d   = StWrRst;
                    w_retry_clr = 1'b1;
                end else if (w_expired) begin
                    w_state_d = StErr;
                end
            end
            StWrRst: w_state_d = StWrWait;
            StNext: begin
                if (r_coeff_idx == LastIdx) begin
                    w_state_d = StFinish;
                end else begin
                    w_state_d   = StRdRst;
                    w_advance   = 1'b1;
                    w_retry_clr = 1'b1;
                end
            end
            StFinish: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_wait      = (r_state == StRdWait) || (r_state == StLiftWait) || (r_state == StWrWait);
        w_phase     = ((r_state == StWrRst) || (r_state == StWrWait)) ? PhWr : PhRd;
        o_iface_rst = (r_state == StIdle) || (r_state == StFinish) || (r_state == StErr) ||
                      (r_state == StRdRst) || (r_state == StWrRst);
    end

    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_error            = r_error;
    assign o_coeff_idx        = r_coeff_idx;
    assign o_iface_read_write = r_read_write;
    assign o_iface_lift_type  = r_lift_type;
    assign o_iface_red_type   = r_red_type;
    assign o_iface_base_in    = r_base_in;
    assign o_iface_base_out   = r_base_out;
    assign o_rst_ddr_offset   = r_rst_ddr_offset;
    assign o_inc_ddr_offset   = r_inc_ddr_offset;
    assign o_lift_start       = r_lift_start;

endmodule

// File: tb/tb_crt_lift_sequencer.sv
// Directed bench: DDR interface model (done 20 cycles after rst falls) and lift model (10 cycles).
module tb_crt_lift_sequencer;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_lift_type_in = 1'b0;
    logic       i_reduction_type_in = 1'b0;
    logic [7:0] i_base_in = 8'h00;
    logic [7:0] i_base_out = 8'h00;
    logic       o_busy, o_done, o_error;
    logic [9:0] o_coeff_idx;
    logic       o_iface_rst, o_iface_read_write, o_iface_lift_type, o_iface_red_type;
    logic [7:0] o_iface_base_in, o_iface_base_out;
    logic       o_rst_ddr_offset, o_inc_ddr_offset, o_lift_start;
    logic       w_iface_done, w_lift_done;

    logic rd_never = 1'b0;
    logic wr_fail_first = 1'b0;
    logic lift_glitch = 1'b0;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    crt_lift_sequencer #(
        .N_COEFF   (4),
        .TIMEOUT_W (6),
        .MAX_RETRY (3)
    ) dut (
        .i_clk_100           (clk),
        .i_rst               (i_rst),
        .i_start             (i_start),
        .i_lift_type_in      (i_lift_type_in),
        .i_reduction_type_in (i_reduction_type_in),
        .i_base_in           (i_base_in),
        .i_base_out          (i_base_out),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_error             (o_error),
        .o_coeff_idx         (o_coeff_idx),
        .o_iface_rst         (o_iface_rst),
        .o_iface_read_write  (o_iface_read_write),
        .o_iface_lift_type   (o_iface_lift_type),
        .o_iface_red_type    (o_iface_red_type),
        .o_iface_base_in     (o_iface_base_in),
        .o_iface_base_out    (o_iface_base_out),
        .o_rst_ddr_offset    (o_rst_ddr_offset),
        .o_inc_ddr_offset    (o_inc_ddr_offset),
        .i_iface_done        (w_iface_done),
        .o_lift_start        (o_lift_start),
        .i_lift_done         (w_lift_done)
    );

    // Interface model; an attempt can be blocked (never reaches done) per test knobs.
    int   m_cnt = 0;
    int   m_wr_att = 0;
    logic m_blk = 1'b0;
    always @(posedge clk) begin
        if (o_iface_rst) begin
            m_cnt    <= 0;
            m_blk    <= o_iface_read_write ?
                        (wr_fail_first && m_wr_att == 0 && o_coeff_idx == 10'd0) : rd_never;
            m_wr_att <= o_iface_read_write ? m_wr_att + 1 : 0;
        end else if (!m_blk && m_cnt != 20) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign w_iface_done = (m_cnt == 20);

    int m_lcnt = 0;
    always @(posedge clk) begin
        if (o_lift_start)       m_lcnt <= 1;
        else if (m_lcnt == 10)  m_lcnt <= 0;
        else if (m_lcnt != 0)   m_lcnt <= m_lcnt + 1;
    end
    assign w_lift_done = (m_lcnt == 10) | lift_glitch;

    int   n_inc = 0, n_done = 0, n_rstoff = 0, n_lstart = 0, n_falls = 0;
    logic prev_irst = 1'b1;
    always @(posedge clk) begin
        n_inc     <= n_inc + int'(o_inc_ddr_offset);
        n_done    <= n_done + int'(o_done);
        n_rstoff  <= n_rstoff + int'(o_rst_ddr_offset);
        n_lstart  <= n_lstart + int'(o_lift_start);
        prev_irst <= o_iface_rst;
        if (prev_irst && !o_iface_rst) n_falls <= n_falls + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_until_end(input int n0, input int limit, output int cnt);
        cnt = n0;
        while (!(o_done === 1'b1 || o_error === 1'b1) && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Ideal offset: RD_RST 1 + RD_WAIT 21 + LIFT 1 + LIFT_WAIT 10 + WR_RST 1 + WR_WAIT 21 + NEXT 1.
    localparam int OffsetCycles = 56;
    localparam int PassCycles   = 4 * OffsetCycles;

    int s_inc, s_done, s_rstoff, s_lstart, s_falls;

    task automatic snap();
        s_inc = n_inc; s_done = n_done; s_rstoff = n_rstoff;
        s_lstart = n_lstart; s_falls = n_falls;
    endtask

    initial begin
        // Reset state
        step(3);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_coeff_idx", o_coeff_idx, 0);
        check("rst_iface_rst", o_iface_rst, 1);
        check("rst_read_write", o_iface_read_write, 0);
        check("rst_pulses", {o_rst_ddr_offset, o_inc_ddr_offset, o_lift_start}, 0);
        check("rst_base_in", o_iface_base_in, 0);
        i_rst = 1'b0;
        tick();

        // Normal pass with timing landmarks
        i_base_in = 8'h12; i_base_out = 8'h34; i_lift_type_in = 1'b1; i_reduction_type_in = 1'b0;
        snap();
        pulse_start();
        check("p1_busy", o_busy, 1);
        check("p1_rst_ddr_offset", o_rst_ddr_offset, 1);
        check("p1_base_in", o_iface_base_in, 8'h12);
        check("p1_base_out", o_iface_base_out, 8'h34);
        check("p1_cfg_types", {o_iface_lift_type, o_iface_red_type}, 2'b10);
        check("p1_rd_rst", o_iface_rst, 1);
        step(1);
        check("p1_rd_wait_rst", o_iface_rst, 0);
        check("p1_rst_off_pulse", o_rst_ddr_offset, 0);
        step(21);
        check("p1_lift_start", o_lift_start, 1);
        step(11);
        check("p1_wr_rst", {o_iface_read_write, o_iface_rst}, 2'b11);
        step(1);
        check("p1_wr_wait", {o_iface_read_write, o_iface_rst}, 2'b10);
        step(22);
        check("p1_inc_offset", {o_inc_ddr_offset, o_coeff_idx}, {1'b1, 10'd1});
        run_until_end(56, 2000, n);
        check("p1_cycles", n, PassCycles);
        check("p1_done_idx", {o_done, o_busy, o_coeff_idx}, {2'b10, 10'd3});
        step(1);
        check("p1_after_done", {o_done, o_iface_rst}, 2'b01);
        step(1);
        check("p1_inc_count", n_inc - s_inc, 3);
        check("p1_done_count", n_done - s_done, 1);
        check("p1_lift_count", n_lstart - s_lstart, 4);

        // Write phase on idx 0 completes only on its second attempt
        wr_fail_first = 1'b1;
        snap();
        pulse_start();
        run_until_end(0, 2000, n);
        check("wr_retry_cycles", n, PassCycles + 65);
        check("wr_retry_done", {o_done, o_error, o_coeff_idx}, {2'b10, 10'd3});
        step(2);
        check("wr_retry_inc_count", n_inc - s_inc, 3);
        check("wr_retry_falls", n_falls - s_falls, 9);
        wr_fail_first = 1'b0;

        // start and lift_done glitch during RD_WAIT are ignored
        snap();
        pulse_start();
        step(5);
        i_start = 1'b1; lift_glitch = 1'b1;
        tick();
        i_start = 1'b0; lift_glitch = 1'b0;
        check("glitch_no_effect", {o_iface_rst, o_lift_start, o_rst_ddr_offset}, 3'b000);
        run_until_end(6, 2000, n);
        check("glitch_cycles", n, PassCycles);
        step(2);
        check("glitch_rstoff_count", n_rstoff - s_rstoff, 1);
        check("glitch_lift_count", n_lstart - s_lstart, 4);

        // Reset in LIFT_WAIT of idx 2
        snap();
        pulse_start();
        step(2 * OffsetCycles + 24);
        check("mid_idx2", {o_busy, o_coeff_idx}, {1'b1, 10'd2});
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("mid_rst_state", {o_busy, o_iface_rst, o_done, o_lift_start}, 4'b0100);
        check("mid_rst_idx", o_coeff_idx, 0);
        check("mid_rst_base", o_iface_base_in, 0);
        step(300);
        check("mid_rst_no_done", n_done - s_done, 0);
        check("mid_rst_idle", o_busy, 0);

        // Read phase never completes: 3 re-issues then error
        rd_never = 1'b1;
        i_base_in = 8'h11;
        snap();
        pulse_start();
        run_until_end(0, 2000, n);
        check("err_cycles", n, 260);
        check("err_flags", {o_error, o_busy, o_done}, 3'b100);
        check("err_idx", o_coeff_idx, 0);
        step(2);
        check("err_rd_attempts", n_falls - s_falls, 4);
        check("err_no_inc", n_inc - s_inc, 0);
        step(5);
        check("err_sticky", {o_error, o_iface_rst}, 2'b11);

        // Restart from ERR with a new read base
        rd_never = 1'b0;
        i_base_in = 8'h40;
        pulse_start();
        check("restart_flags", {o_error, o_busy, o_rst_ddr_offset}, 3'b011);
        check("restart_base_in", o_iface_base_in, 8'h40);
        run_until_end(0, 2000, n);
        check("restart_cycles", n, PassCycles);
        check("restart_done", {o_done, o_error}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
